// File: rtl/pu_msp430_timer_lite.sv
// 16-bit peripheral timer: prescaler, compare register, maskable IRQ; reads are combinational in the access cycle.
// Writes land at the edge that ends the access; zero wait states, never back-pressures the bus.
module pu_msp430_timer_lite #(
  parameter logic [14:0] BASE_ADDR = 15'h0160
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        irq_acc,
  output logic [15:0] per_dout,
  output logic        irq
);

  localparam logic [1:0] OFF_CTL  = 2'd0;
  localparam logic [1:0] OFF_CNT  = 2'd1;
  localparam logic [1:0] OFF_CCR  = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  logic        en_q, en_d;
  logic        mode_q, mode_d;
  logic [1:0]  div_q, div_d;
  logic        ie_q, ie_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ccr_q, ccr_d;
  logic        ifg_q, ifg_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  div_cnt_q, div_cnt_d;

  logic        reg_sel, reg_wr, reg_rd;
  logic [1:0]  off;
  logic        ctl_wr_lo, stat_wr_lo, clr;
  logic [2:0]  div_term;
  logic        tick, tick_eff, match;
  logic        set_ifg, set_ovf;

  function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  be);
    byte_merge = {be[1] ? new_v[15:8] : old_v[15:8],
                  be[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

  assign reg_sel    = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
  assign off        = per_addr[1:0];
  assign reg_wr     = reg_sel & (per_we != 2'b00);
  assign reg_rd     = reg_sel & (per_we == 2'b00);
  assign ctl_wr_lo  = reg_wr & (off == OFF_CTL) & per_we[0];
  assign stat_wr_lo = reg_wr & (off == OFF_STAT) & per_we[0];
  assign clr        = ctl_wr_lo & per_din[5];

  always_comb begin
    div_term = 3'd0;
    case (div_q)
      2'd0: div_term = 3'd0;
      2'd1: div_term = 3'd1;
      2'd2: div_term = 3'd3;
      default: div_term = 3'd7;
    endcase
  end

  assign tick     = en_q & (div_cnt_q == div_term);
  // CLR suppresses every side effect of a coincident tick, flags included.
  assign tick_eff = tick & ~clr;
  assign match    = (cnt_q == ccr_q);
  assign set_ifg  = tick_eff & match;
  assign set_ovf  = tick_eff & (cnt_q == 16'hFFFF) & ~(mode_q & match);

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    div_d     = div_q;
    ie_d      = ie_q;
    cnt_d     = cnt_q;
    ccr_d     = ccr_q;
    div_cnt_d = div_cnt_q;

    if (en_q) begin
      div_cnt_d = tick ? 3'd0 : div_cnt_q + 3'd1;
    end
    if (tick_eff) begin
      cnt_d = (mode_q & match) ? 16'h0000 : cnt_q + 16'd1;
    end

    if (ctl_wr_lo) begin
      en_d   = per_din[0];
      mode_d = per_din[1];
      div_d  = per_din[3:2];
      ie_d   = per_din[4];
    end
    // Software writes override the tick's counter update, using the pre-tick value for untouched bytes.
    if (reg_wr && off == OFF_CNT) begin
      cnt_d = byte_merge(cnt_q, per_din, per_we);
    end
    if (reg_wr && off == OFF_CCR) begin
      ccr_d = byte_merge(ccr_q, per_din, per_we);
    end
    if (clr) begin
      cnt_d     = 16'h0000;
      div_cnt_d = 3'd0;
    end

    ifg_d = set_ifg | (ifg_q & ~(stat_wr_lo & per_din[0]) & ~irq_acc);
    ovf_d = set_ovf | (ovf_q & ~(stat_wr_lo & per_din[1]));
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      div_q     <= 2'd0;
      ie_q      <= 1'b0;
      cnt_q     <= 16'h0000;
      ccr_q     <= 16'h0000;
      ifg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      div_cnt_q <= 3'd0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      ie_q      <= ie_d;
      cnt_q     <= cnt_d;
      ccr_q     <= ccr_d;
      ifg_q     <= ifg_d;
      ovf_q     <= ovf_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (off)
        OFF_CTL:  per_dout = {11'd0, ie_q, div_q, mode_q, en_q};
        OFF_CNT:  per_dout = cnt_q;
        OFF_CCR:  per_dout = ccr_q;
        default:  per_dout = {14'd0, ovf_q, ifg_q};
      endcase
    end
  end

  assign irq = ie_q & ifg_q;

endmodule
